// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit memory controller.
// Latency: none (declarations and a pure request-checking function).
// Backpressure: n/a.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // Classify a request: ERR_NONE when it can go to the bus. Illegal encodings
   // (including simultaneous load and store) take priority over misalignment.
   function automatic logic [1:0] req_err(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
      logic [1:0] err;
      err = ERR_ILLEGAL;
      if (!(rd && wr)) begin
         case (f3)
            F3_B:    err = ERR_NONE;
            F3_H:    err = off[0] ? ERR_MISALIGN : ERR_NONE;
            F3_W:    err = (off != 2'b00) ? ERR_MISALIGN : ERR_NONE;
            F3_BU:   err = rd ? ERR_NONE : ERR_ILLEGAL;
            F3_HU:   err = !rd ? ERR_ILLEGAL : (off[0] ? ERR_MISALIGN : ERR_NONE);
            default: err = ERR_ILLEGAL;
         endcase
      end
      return err;
   endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Lane formatting: store byte enables + data replication, load extract + extend.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_lane_fmt
   import lsu_pkg::*;
(
   input  logic [2:0]  st_f3,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_f3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] ld_shifted;

   // Byte enables and lane-replicated data for the access size (loads use the enables too).
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_f3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << st_off;
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Move the addressed byte/halfword down to bit 0, then sign- or zero-extend.
   always_comb begin
      ld_shifted = ld_word >> {ld_off, 3'b000};
      case (ld_f3)
         F3_B:    ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
         F3_BU:   ld_data = {24'b0, ld_shifted[7:0]};
         F3_H:    ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
         F3_HU:   ld_data = {16'b0, ld_shifted[15:0]};
         default: ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one aligned bus transaction per access, error flagging, core stall.
// Latency: request cycle + >=1 BUSY cycle, result visible in the following DONE cycle.
// Backpressure: Stall held while waiting on mem_ready; aborted after TIMEOUT BUSY cycles.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [2:0]  funct3,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AccessErr,
   output logic [1:0]  ErrCode,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   // Counter value seen in the last BUSY cycle before abort.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   lsu_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [1:0]  code_q, code_d;

   logic        req;
   logic [1:0]  req_code;
   logic [3:0]  fmt_be;
   logic [31:0] fmt_wdata;
   logic [31:0] fmt_ld;

   assign req      = MemRead | MemWrite;
   assign req_code = req_err(MemRead, MemWrite, funct3, Addr[1:0]);

   lsu_lane_fmt u_fmt (
      .st_f3    (funct3),
      .st_off   (Addr[1:0]),
      .st_data  (WriteData),
      .st_be    (fmt_be),
      .st_wdata (fmt_wdata),
      .ld_f3    (f3_q),
      .ld_off   (off_q),
      .ld_word  (mem_rdata),
      .ld_data  (fmt_ld)
   );

   // Stall is combinational so the core holds PC in the very cycle a valid request appears.
   always_comb begin
      Stall = (state_q == BUSY) || ((state_q == IDLE) && req && (req_code == ERR_NONE));
   end

   // Next-state: launch, wait/complete/abort, and the one-cycle retire slot.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      f3_d        = f3_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      err_d       = 1'b0;
      code_d      = code_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (req_code == ERR_NONE) begin
                  state_d     = BUSY;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = MemWrite;
                  mem_addr_d  = {Addr[31:2], 2'b00};
                  mem_be_d    = fmt_be;
                  mem_wdata_d = fmt_wdata;
                  f3_d        = funct3;
                  off_d       = Addr[1:0];
               end else begin
                  err_d   = 1'b1;
                  code_d  = req_code;
                  rdata_d = 32'd0;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 8'd1;
            // Completion beats timeout when both land in the same cycle.
            if (mem_ready) begin
               if (!mem_we_q) begin
                  rdata_d = fmt_ld;
               end
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
               state_d   = DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
               err_d     = 1'b1;
               code_d    = ERR_TIMEOUT;
               rdata_d   = 32'd0;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset drops an in-flight request immediately.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'd0;
         mem_be_q    <= 4'b0000;
         mem_wdata_q <= 32'd0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         rdata_q     <= 32'd0;
         err_q       <= 1'b0;
         code_q      <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         code_q      <= code_d;
      end
   end

   assign ReadData  = rdata_q;
   assign AccessErr = err_q;
   assign ErrCode   = code_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: transaction-level reference model plus directed accesses.
// Latency: n/a.
// Backpressure: mem_ready delay chosen per access, including never (timeout).
module tb_lsu_mem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n, MemWrite, MemRead, mem_ready;
   logic [2:0]  funct3;
   logic [31:0] Addr, WriteData, mem_rdata;
   logic [31:0] ReadData, mem_addr, mem_wdata;
   logic        Stall, AccessErr, mem_req, mem_we;
   logic [1:0]  ErrCode;
   logic [3:0]  mem_be;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemRead(MemRead),
      .funct3(funct3), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
      .Stall(Stall), .AccessErr(AccessErr), .ErrCode(ErrCode), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int acc_size(input logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   // 0 ok, 1 misaligned, 2 illegal
   function automatic logic [1:0] classify(input logic rd, input logic wr,
                                           input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      if (rd && wr) return 2'd2;
      if (rd) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      if (!legal) return 2'd2;
      if ((int'(a[1:0]) % acc_size(f3)) != 0) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [31:0] a);
      int v;
      v = ((1 << acc_size(f3)) - 1) << int'(a[1:0]);
      return v[3:0];
   endfunction

   function automatic logic [31:0] wd_model(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] r;
      int sz;
      sz = acc_size(f3);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      logic [31:0] v;
      int sz;
      sz = acc_size(f3);
      v  = w >> (8 * int'(off));
      if (sz == 4) return w;
      if (sz == 1) begin
         v = v & 32'h0000_00FF;
         if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
      end else begin
         v = v & 32'h0000_FFFF;
         if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   bit          m_init = 0, m_busy = 0, m_retire = 0;
   int          m_wait = 0;
   logic        m_we, m_err;
   logic [2:0]  m_f3;
   logic [31:0] m_a, m_wd, m_rd;
   logic [1:0]  m_code, m_cls;

   // One transaction in flight at a time; a retiring cycle ignores requests.
   always @(posedge clk) begin
      m_err = 1'b0;
      if (!rst_n) begin
         m_init = 1; m_busy = 0; m_retire = 0; m_rd = 32'd0; m_code = 2'd0;
      end else if (m_busy) begin
         m_wait++;
         if (mem_ready) begin
            if (!m_we) m_rd = ld_model(m_f3, m_a[1:0], mem_rdata);
            m_busy = 0; m_retire = 1;
         end else if (m_wait == TO) begin
            m_rd = 32'd0; m_err = 1'b1; m_code = 2'd3;
            m_busy = 0; m_retire = 1;
         end
      end else if (m_retire) begin
         m_retire = 0;
      end else if (MemRead || MemWrite) begin
         m_cls = classify(MemRead, MemWrite, funct3, Addr);
         if (m_cls == 2'd0) begin
            m_busy = 1; m_wait = 0; m_we = MemWrite; m_f3 = funct3; m_a = Addr; m_wd = WriteData;
         end else begin
            m_err = 1'b1; m_code = m_cls; m_rd = 32'd0;
         end
      end
   end

   // Per-cycle comparison against the model, away from the clock edge.
   always @(negedge clk) begin
      logic exp_stall;
      #2;
      if (m_init) begin
         exp_stall = m_busy || (!m_retire && (MemRead || MemWrite) &&
                                classify(MemRead, MemWrite, funct3, Addr) == 2'd0);
         chk("stall", Stall, exp_stall);
         chk("mem_req", mem_req, m_busy);
         chk("access_err", AccessErr, m_err);
         chk("err_code", ErrCode, m_code);
         chk("read_data", ReadData, m_rd);
         if (m_busy) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, {m_a[31:2], 2'b00});
            chk("mem_be", mem_be, be_model(m_f3, m_a));
            if (m_we) chk("mem_wdata", mem_wdata, wd_model(m_f3, m_wd));
         end
      end
   end

   // ---------------- stimulus ----------------
   // Core holds the request through stall and the retire cycle, then drops it.
   task automatic access(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int dly,
                         input logic [31:0] rdata, output int stalls,
                         output logic [3:0] be_seen, output logic [31:0] wd_seen,
                         output logic [31:0] addr_seen, output logic we_seen);
      int k;
      stalls = 0; be_seen = 4'd0; wd_seen = 32'd0; addr_seen = 32'd0; we_seen = 1'b0;
      @(negedge clk);
      MemWrite = wr; MemRead = rd; funct3 = f3; Addr = a; WriteData = wd;
      mem_ready = 1'b0; mem_rdata = rdata;
      #1;
      if (Stall) begin
         stalls = 1;
         k = 0;
         while (Stall && k < 20) begin
            k++;
            @(negedge clk);
            mem_ready = (k == dly);
            #1;
            if (Stall) begin
               stalls++;
               be_seen = mem_be; wd_seen = mem_wdata; addr_seen = mem_addr; we_seen = mem_we;
            end
         end
         chk("done_reached", Stall, 1'b0);
      end
      @(negedge clk);
      MemWrite = 1'b0; MemRead = 1'b0; mem_ready = 1'b0;
      #1;
   endtask

   int          st;
   logic [3:0]  be;
   logic [31:0] wdv, av;
   logic        wev;

   initial begin
      rst_n = 1'b0; MemWrite = 1'b0; MemRead = 1'b0; funct3 = 3'd0; Addr = 32'd0;
      WriteData = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_read_data", ReadData, 32'd0);
      chk("rst_err_code", ErrCode, 2'b00);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_stall", Stall, 1'b0);

      // SW, ready after one BUSY cycle
      access(1, 0, 3'b010, 32'h1004, 32'hDEADBEEF, 1, 32'd0, st, be, wdv, av, wev);
      chk("sw_stall_cycles", st, 2);
      chk("sw_be", be, 4'b1111);
      chk("sw_addr", av, 32'h1004);
      chk("sw_we", wev, 1'b1);
      chk("sw_wdata", wdv, 32'hDEADBEEF);

      // LB / LBU top byte
      access(0, 1, 3'b000, 32'h2003, 32'd0, 1, 32'h80FF_0000, st, be, wdv, av, wev);
      chk("lb_be", be, 4'b1000);
      chk("lb_data", ReadData, 32'hFFFF_FF80);
      access(0, 1, 3'b100, 32'h2003, 32'd0, 2, 32'h80FF_0000, st, be, wdv, av, wev);
      chk("lbu_data", ReadData, 32'h0000_0080);

      // SH then LHU upper halfword
      access(1, 0, 3'b001, 32'h3002, 32'h0000_1234, 1, 32'd0, st, be, wdv, av, wev);
      chk("sh_be", be, 4'b1100);
      chk("sh_wdata", wdv, 32'h1234_1234);
      chk("sh_keeps_read_data", ReadData, 32'h0000_0080);
      access(0, 1, 3'b101, 32'h3002, 32'd0, 1, 32'hABCD_0000, st, be, wdv, av, wev);
      chk("lhu_data", ReadData, 32'h0000_ABCD);

      // error cases
      access(0, 1, 3'b010, 32'h1001, 32'd0, 1, 32'd0, st, be, wdv, av, wev);
      chk("misalign_stall", st, 0);
      chk("misalign_pulse", AccessErr, 1'b1);
      chk("misalign_code", ErrCode, 2'b01);
      chk("misalign_read_data", ReadData, 32'd0);
      access(0, 1, 3'b011, 32'h1000, 32'd0, 1, 32'd0, st, be, wdv, av, wev);
      chk("illegal_load_code", ErrCode, 2'b10);
      access(1, 0, 3'b100, 32'h1000, 32'd0, 1, 32'd0, st, be, wdv, av, wev);
      chk("illegal_store_code", ErrCode, 2'b10);
      access(0, 1, 3'b001, 32'h1003, 32'd0, 1, 32'd0, st, be, wdv, av, wev);
      chk("lh_misalign_code", ErrCode, 2'b01);
      access(1, 1, 3'b000, 32'h1000, 32'd0, 1, 32'd0, st, be, wdv, av, wev);
      chk("both_req_code", ErrCode, 2'b10);

      // LH sign extend, LW with longer wait
      access(0, 1, 3'b001, 32'h2002, 32'd0, 1, 32'h8001_0000, st, be, wdv, av, wev);
      chk("lh_data", ReadData, 32'hFFFF_8001);
      access(0, 1, 3'b010, 32'h1008, 32'd0, 2, 32'h1234_5678, st, be, wdv, av, wev);
      chk("lw_stall_cycles", st, 3);
      chk("lw_data", ReadData, 32'h1234_5678);

      // timeout, then completion on the last allowed cycle
      access(0, 1, 3'b010, 32'h1000, 32'd0, 0, 32'h5555_5555, st, be, wdv, av, wev);
      chk("timeout_stall_cycles", st, 1 + TO);
      chk("timeout_code", ErrCode, 2'b11);
      chk("timeout_read_data", ReadData, 32'd0);
      access(0, 1, 3'b010, 32'h1000, 32'd0, TO, 32'hCAFE_F00D, st, be, wdv, av, wev);
      chk("last_cycle_stall_cycles", st, 1 + TO);
      chk("last_cycle_data", ReadData, 32'hCAFE_F00D);
      chk("last_cycle_code_held", ErrCode, 2'b11);

      // reset in BUSY, late mem_ready ignored
      @(negedge clk);
      MemRead = 1'b1; funct3 = 3'b010; Addr = 32'h1010; mem_rdata = 32'h7777_7777;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; MemRead = 1'b0; mem_ready = 1'b1;
      #1;
      chk("rst_busy_mem_req", mem_req, 1'b0);
      chk("rst_busy_stall", Stall, 1'b0);
      chk("rst_busy_read_data", ReadData, 32'd0);
      chk("rst_busy_err_code", ErrCode, 2'b00);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("late_ready_read_data", ReadData, 32'd0);
      chk("late_ready_pulse", AccessErr, 1'b0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
